// File: rtl/led_pio_sequencer.sv
// Autonomous LED pattern sequencer: replays an 8-entry pattern table into a PIO over Avalon-MM.
// Optional feature macro LED_SEQ_IRQ_EN adds the registered irq output and the CTRL[2] irq_en bit.

module led_pio_sequencer #(
  parameter int DWELL_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, DWELL} state_e;

  state_e                 state_q, state_d;
  logic                   run_q, run_d;
  logic                   loop_q, loop_d;
  logic                   done_q, done_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [DWELL_WIDTH-1:0] dwell_eff;
  logic [3:0]             length_q, length_d;
  logic [3:0]             len_eff;
  logic [2:0]             idx_q, idx_d;
  logic [2:0]             idx_inc;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            pattern_q [8];
  logic [31:0]            pattern_d [8];
  logic                   s_wr;
  logic                   irq_en_rd;

`ifdef LED_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;
  assign irq_en_rd = irq_en_q;
  assign irq       = irq_q;
`else
  assign irq_en_rd = 1'b0;
`endif

  assign s_wr      = s_chipselect & ~s_write_n;
  assign dwell_eff = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
  assign idx_inc   = idx_q + 3'd1;

  always_comb begin
    if (length_q == 4'd0)      len_eff = 4'd1;
    else if (length_q > 4'd8)  len_eff = 4'd8;
    else                       len_eff = length_q;
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    loop_d    = loop_q;
    done_d    = done_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    length_d  = length_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    pattern_d = pattern_q;
`ifdef LED_SEQ_IRQ_EN
    irq_en_d  = irq_en_q;
`endif

    if (s_wr) begin
      case (s_address)
        4'd0: begin
          run_d  = s_writedata[0];
          loop_d = s_writedata[1];
`ifdef LED_SEQ_IRQ_EN
          irq_en_d = s_writedata[2];
`endif
        end
        4'd1: if (s_writedata[1]) done_d = 1'b0;
        4'd2: dwell_d  = s_writedata[DWELL_WIDTH-1:0];
        4'd3: length_d = s_writedata[3:0];
        default: if (s_address[3]) pattern_d[s_address[2:0]] = s_writedata;
      endcase
    end

    // Sequencer updates come after the register writes so a hardware done-set
    // beats a same-cycle W1C, and completion's run-clear beats a CTRL write.
    case (state_q)
      IDLE: begin
        if (run_d) begin
          state_d = WRITE;
          idx_d   = 3'd0;
          wdata_d = pattern_q[0];
        end
      end
      WRITE: begin
        if (!m_waitrequest) begin
          cnt_d   = dwell_eff;
          state_d = DWELL;
        end
      end
      DWELL: begin
        cnt_d = cnt_q - DWELL_WIDTH'(1);
        if (cnt_q == DWELL_WIDTH'(1)) begin
          if (!run_d) begin
            state_d = IDLE;
          end else if ({1'b0, idx_q} < (len_eff - 4'd1)) begin
            idx_d   = idx_inc;
            wdata_d = pattern_q[idx_inc];
            state_d = WRITE;
          end else if (loop_q) begin
            idx_d   = 3'd0;
            wdata_d = pattern_q[0];
            state_d = WRITE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            run_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LED_SEQ_IRQ_EN
  assign irq_d = done_d & irq_en_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      done_q   <= 1'b0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      length_q <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < 8; i++) pattern_q[i] <= '0;
`ifdef LED_SEQ_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      loop_q    <= loop_d;
      done_q    <= done_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      length_q  <= length_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      pattern_q <= pattern_d;
`ifdef LED_SEQ_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

  assign m_address    = 2'b00;
  assign m_chipselect = (state_q == WRITE);
  assign m_write_n    = (state_q != WRITE);
  assign m_writedata  = wdata_q;

  always_comb begin
    s_readdata = '0;
    case (s_address)
      4'd0: s_readdata = {29'd0, irq_en_rd, loop_q, run_q};
      4'd1: s_readdata = {25'd0, idx_q, 2'd0, done_q, (state_q != IDLE)};
      4'd2: s_readdata[DWELL_WIDTH-1:0] = dwell_q;
      4'd3: s_readdata[3:0] = length_q;
      default: if (s_address[3]) s_readdata = pattern_q[s_address[2:0]];
    endcase
  end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed self-checking bench for led_pio_sequencer; PIO writes are logged with their cycle numbers.
// IRQ checks are compiled in when LED_SEQ_IRQ_EN is defined.

module tb_led_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  s_address = '0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_s_wr = 0;
  int          start_cyc;
  logic [31:0] rd;
  logic [31:0] wr_log [$];
  int          wr_cyc [$];

  led_pio_sequencer #(.DWELL_WIDTH(24)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_waitrequest(m_waitrequest)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  // Log every completed PIO transfer and the cycle of the latest config write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && m_chipselect && !m_write_n && !m_waitrequest) begin
      wr_log.push_back(m_writedata);
      wr_cyc.push_back(cyc);
    end
    if (s_chipselect && !s_write_n) last_s_wr = cyc;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    s_address    = addr;
    s_writedata  = data;
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    @(posedge clk); #1;
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [3:0] addr, output logic [31:0] data);
    s_address = addr;
    #1;
    data = s_readdata;
  endtask

  task automatic clear_log();
    wr_log.delete();
    wr_cyc.delete();
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : -1000;
  endfunction

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_cs", m_chipselect, 0);
    check_output("rst_wn", m_write_n, 1);
    check_output("rst_wdata", m_writedata, 0);
    check_output("rst_maddr", m_address, 0);
    read_reg(4'd0, rd); check_output("rst_ctrl", rd, 0);
    read_reg(4'd1, rd); check_output("rst_status", rd, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // One-shot run: 3 patterns, dwell 5 -> writes 6 clocks apart
    apply_stimulus(4'd8, 32'h1);
    apply_stimulus(4'd9, 32'h2);
    apply_stimulus(4'd10, 32'h4);
    apply_stimulus(4'd3, 32'd3);
    apply_stimulus(4'd2, 32'd5);
    read_reg(4'd2, rd); check_output("dwell_rb", rd, 5);
    read_reg(4'd3, rd); check_output("length_rb", rd, 3);
    clear_log();
    apply_stimulus(4'd0, 32'h1);
    start_cyc = last_s_wr;
    check_output("os_cs_n1", m_chipselect, 1);
    check_output("os_wn_n1", m_write_n, 0);
    check_output("os_wdata0", m_writedata, 32'h1);
    repeat (3) @(posedge clk);
    read_reg(4'd1, rd); check_output("os_status_busy", rd, 32'h01);
    repeat (25) @(posedge clk);
    #1;
    check_output("os_count", wr_log.size(), 3);
    check_output("os_d0", log_at(0), 32'h1);
    check_output("os_d1", log_at(1), 32'h2);
    check_output("os_d2", log_at(2), 32'h4);
    check_output("os_lat", cyc_at(0) - start_cyc, 1);
    check_output("os_gap1", cyc_at(1) - cyc_at(0), 6);
    check_output("os_gap2", cyc_at(2) - cyc_at(1), 6);
    read_reg(4'd1, rd); check_output("os_status_done", rd, 32'h22);
    read_reg(4'd0, rd); check_output("os_ctrl_runclr", rd, 0);
    apply_stimulus(4'd1, 32'h2);
    read_reg(4'd1, rd); check_output("os_w1c", rd, 32'h20);

    // Loop, dwell 0, second write stalled for 3 clocks
    apply_stimulus(4'd3, 32'd2);
    apply_stimulus(4'd2, 32'd0);
    clear_log();
    apply_stimulus(4'd0, 32'h3);
    check_output("lp_wdata0", m_writedata, 32'h1);
    @(posedge clk); #1;
    m_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_output("lp_stall_cs", m_chipselect, 1);
      check_output("lp_stall_wdata", m_writedata, 32'h2);
    end
    m_waitrequest = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_output("lp_count", wr_log.size(), 7);
    for (int i = 0; i < 6; i++)
      check_output("lp_alt", log_at(i), (i % 2 == 0) ? 32'h1 : 32'h2);
    check_output("lp_stall_gap", cyc_at(1) - cyc_at(0), 5);
    check_output("lp_gap", cyc_at(2) - cyc_at(1), 2);
    apply_stimulus(4'd0, 32'h0);
    repeat (10) @(posedge clk);
    read_reg(4'd1, rd); check_output("lp_stop_status", rd & 32'h3, 0);
    clear_log();
    repeat (10) @(posedge clk);
    #1;
    check_output("lp_stop_quiet", wr_log.size(), 0);

    // Mid-run stop during DWELL at idx 1
    apply_stimulus(4'd2, 32'd5);
    apply_stimulus(4'd3, 32'd3);
    clear_log();
    apply_stimulus(4'd0, 32'h1);
    repeat (8) @(posedge clk);
    read_reg(4'd1, rd); check_output("st_status_mid", rd, 32'h11);
    apply_stimulus(4'd0, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check_output("st_count", wr_log.size(), 2);
    check_output("st_d1", log_at(1), 32'h2);
    read_reg(4'd1, rd); check_output("st_status_end", rd, 32'h10);

    // Clamping: LENGTH=12 -> 8 writes, LENGTH=0 -> 1 write
    apply_stimulus(4'd11, 32'h08);
    apply_stimulus(4'd12, 32'h10);
    apply_stimulus(4'd13, 32'h20);
    apply_stimulus(4'd14, 32'h40);
    apply_stimulus(4'd15, 32'h80);
    apply_stimulus(4'd2, 32'd1);
    apply_stimulus(4'd3, 32'd12);
    read_reg(4'd3, rd); check_output("cl_len_rb", rd, 32'hC);
    read_reg(4'd4, rd); check_output("unmapped_rd", rd, 0);
    clear_log();
    apply_stimulus(4'd0, 32'h1);
    repeat (30) @(posedge clk);
    #1;
    check_output("cl8_count", wr_log.size(), 8);
    check_output("cl8_d3", log_at(3), 32'h08);
    check_output("cl8_d7", log_at(7), 32'h80);
    read_reg(4'd1, rd); check_output("cl8_status", rd, 32'h72);
    apply_stimulus(4'd1, 32'h2);
    apply_stimulus(4'd3, 32'd0);
    clear_log();
    apply_stimulus(4'd0, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    check_output("cl1_count", wr_log.size(), 1);
    check_output("cl1_d0", log_at(0), 32'h1);
    read_reg(4'd1, rd); check_output("cl1_status", rd, 32'h02);
    apply_stimulus(4'd1, 32'h2);

`ifdef LED_SEQ_IRQ_EN
    apply_stimulus(4'd3, 32'd1);
    apply_stimulus(4'd0, 32'h5);
    check_output("irq_low_busy", irq, 0);
    repeat (10) @(posedge clk);
    #1;
    check_output("irq_high", irq, 1);
    read_reg(4'd1, rd); check_output("irq_status", rd, 32'h02);
    read_reg(4'd0, rd); check_output("irq_ctrl", rd, 32'h4);
    apply_stimulus(4'd1, 32'h2);
    check_output("irq_w1c", irq, 0);
`else
    apply_stimulus(4'd0, 32'h4);
    read_reg(4'd0, rd); check_output("ctrl2_ro", rd, 0);
`endif

    // Asynchronous reset while a transfer is stalled
    m_waitrequest = 1'b1;
    apply_stimulus(4'd0, 32'h1);
    check_output("ar_cs_before", m_chipselect, 1);
    reset_n = 1'b0;
    #1;
    check_output("ar_cs", m_chipselect, 0);
    check_output("ar_wn", m_write_n, 1);
    check_output("ar_wdata", m_writedata, 0);
    read_reg(4'd1, rd); check_output("ar_status", rd, 0);
    read_reg(4'd8, rd); check_output("ar_pattern0", rd, 0);
    m_waitrequest = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pio_sequencer.md
# led_pio_sequencer

Autonomous LED pattern sequencer that drives the 32-bit LED PIO slave over Avalon-MM so LED animations run without HPS involvement. The HPS configures it through a small Avalon-MM slave: an 8-entry pattern table, dwell time, sequence length and loop mode. Once started, the sequencer writes successive patterns to PIO register 0 (data_out), holding each for a programmed number of clocks. It sits between the HPS lightweight bridge and the LED PIO in the soc_design fabric.

## Interface
- DWELL_WIDTH, 24, width of the dwell counter and DWELL register (clocks per pattern step).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  4  config slave word address.
- s_chipselect  in  1  config slave select.
- s_write_n  in  1  config slave write strobe, active low.
- s_writedata  in  32  config write data.
- s_readdata  out  32  config read data; combinational, zero wait states.
- m_address  out  2  master address to PIO; constant 0.
- m_chipselect  out  1  master select.
- m_write_n  out  1  master write strobe, active low.
- m_writedata  out  32  pattern value to PIO.
- m_waitrequest  in  1  interconnect stall; tie 0 when connected directly.
- irq  out  1  completion interrupt (present only with LED_SEQ_IRQ_EN).

## Operation
- Register map (word addresses):
  - 0 CTRL: [0] run, [1] loop, [2] irq_en.
  - 1 STATUS: [0] busy (RO), [1] done (W1C), [6:4] current index (RO).
  - 2 DWELL: [DWELL_WIDTH-1:0].
  - 3 LENGTH: [3:0].
  - 8..15 PATTERN[0..7].
  - Other addresses read 0; writes to them are ignored.
- Reset values: all registers 0; s_readdata 0; m_chipselect 0; m_write_n 1; m_writedata 0; m_address 0; irq 0.
- Effective length = 1 if LENGTH==0; 8 if LENGTH>8; otherwise LENGTH. Effective dwell = max(DWELL,1).
- FSM states: IDLE, WRITE, DWELL.
  - IDLE: busy=0. Transition to WRITE with idx=0 when run==1.
  - WRITE: m_chipselect=1, m_write_n=0, m_writedata=PATTERN[idx]. Hold all master outputs stable while m_waitrequest==1. On the cycle where m_waitrequest==0, the transfer completes; load the dwell counter with effective dwell and go to DWELL.
  - DWELL: decrement the counter each clock. At counter==1:
    - If run==0, go to IDLE (stop).
    - Else if idx < len-1, set idx+1 and go to WRITE.
    - Else if loop==1, set idx=0 and go to WRITE.
    - Else go to IDLE, set done=1 and clear run.
- Stop mid-run: writing run=0 never aborts an in-flight WRITE. The sequencer completes the current transfer and dwell, then returns to IDLE. done is not set on a stop.
- Writing run=1 while busy has no effect on sequencing. loop and irq_en take effect immediately.
- PATTERN, DWELL and LENGTH writes while busy are legal. New values apply at the next fetch or counter load.
- Simultaneous hardware done-set and software W1C in the same cycle: set wins.

## Timing
- CTRL write of run=1 at cycle N puts m_chipselect high at N+1.
- With m_waitrequest==0, each step takes 1 + effective dwell clocks. The PIO's out_port changes once per step.
- done and irq assert on the clock after the final dwell expires, together with busy falling.
- s_readdata is combinational from s_address and the registers.

## Configuration
- LED_SEQ_IRQ_EN defined:
  - irq port exists.
  - irq = done & irq_en, registered.
  - CTRL[2] is read/write.
- LED_SEQ_IRQ_EN undefined:
  - No irq port.
  - CTRL[2] reads 0 and writes are ignored.
  - done remains pollable.

## Test plan
- Reset check: assert reset_n low mid-WRITE -> all outputs return to their reset values immediately; STATUS reads 0.
- One-shot run: PATTERN[0..2]=0x1,0x2,0x4; LENGTH=3; DWELL=5; CTRL=0x1 -> three PIO writes spaced 6 clocks apart; then done=1, run=0, busy=0.
- Loop with stall: loop=1, LENGTH=2, DWELL=0. Hold m_waitrequest high for 3 clocks on the second write -> m_writedata stays at 0x2 while stalled; the sequence then alternates 0x1/0x2 indefinitely.
- Mid-run stop: write CTRL=0 during DWELL at idx=1 -> no further master writes once the dwell expires; busy=0; done=0.
- Clamping: LENGTH=12 -> exactly 8 writes (PATTERN[0..7]) before done. LENGTH=0 -> exactly 1 write.
- IRQ (with LED_SEQ_IRQ_EN): irq_en=1, one-shot run -> irq rises with done. W1C write to STATUS bit1 -> irq drops the next clock.
